// File: rtl/ea_sequencer.sv
// ea_sequencer: resolves PDP-8 memory-reference effective addresses.
// It handles direct (page zero / current page) and indirect references, and
// autoindex pre-increment write-back for locations AI_LO..AI_HI. It drives
// the memory_controller request port with single-cycle request pulses.
//
// Optional feature macro: AUTOINDEX_EN
//   defined   : indirect references through AI_LO..AI_HI write ptr+1 back and return it
//   undefined : no autoindex write-back; those references behave as plain indirect
//
// Ports:
//   clk_i             system clock
//   reset_i           synchronous, active-high reset
//   start_i           request EA resolution (sampled only in IDLE)
//   instr_i[11:0]     instruction: [8]=indirect, [7]=current page, [6:0]=offset
//   pc_i[11:0]        address of the instruction being resolved
//   mem_read_data_i   read data from the memory controller
//   mem_address_o     request address
//   mem_write_data_o  request write data
//   mem_read_enable_o read request pulse
//   mem_read_type_o   read type (always DATA_READ)
//   mem_write_enable_o write request pulse
//   ea_o              resolved effective address (holds between strobes)
//   ea_valid_o        one-cycle strobe, ea_o valid
//   busy_o            high from the cycle after acceptance until ea_valid_o

`ifndef DATA_READ
`define DATA_READ 1'b0
`endif

module ea_sequencer #(
  parameter logic [11:0] AI_LO = 12'o0010,
  parameter logic [11:0] AI_HI = 12'o0017
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [11:0] instr_i,
  input  logic [11:0] pc_i,
  input  logic [11:0] mem_read_data_i,
  output logic [11:0] mem_address_o,
  output logic [11:0] mem_write_data_o,
  output logic        mem_read_enable_o,
  output logic        mem_read_type_o,
  output logic        mem_write_enable_o,
  output logic [11:0] ea_o,
  output logic        ea_valid_o,
  output logic        busy_o
);

  localparam int unsigned AW = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IND_RD   = 3'd1,
    IND_WAIT = 3'd2,
`ifdef AUTOINDEX_EN
    AI_WR    = 3'd3,
`endif
    DONE     = 3'd4
  } state_e;

  // Where an indirect through an autoindex location goes after the pointer read.
`ifdef AUTOINDEX_EN
  localparam state_e AI_NEXT = AI_WR;
`else
  localparam state_e AI_NEXT = DONE;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   mem_address_q, mem_address_d;
  logic [AW-1:0]   mem_write_data_q, mem_write_data_d;
  logic            rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_type_q, rd_type_d;
  logic [AW-1:0]   ea_q, ea_d;
  logic            ea_valid_q, ea_valid_d;
  logic            busy_q, busy_d;

  logic [AW-1:0]   direct_c;
  logic            ai_hit_c;
  logic            unused_c;

  // Direct address: page zero or the page holding the instruction.
  assign direct_c = instr_i[7] ? {pc_i[11:7], instr_i[6:0]} : {5'b0, instr_i[6:0]};
  assign ai_hit_c = (addr_q >= AI_LO) && (addr_q <= AI_HI);

  // Opcode bits and in-page pc bits do not contribute to the EA.
  assign unused_c = ^{instr_i[11:9], pc_i[6:0]};

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      rd_en_q          <= 1'b0;
      wr_en_q          <= 1'b0;
      rd_type_q        <= `DATA_READ;
      ea_q             <= '0;
      ea_valid_q       <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      rd_en_q          <= rd_en_d;
      wr_en_q          <= wr_en_d;
      rd_type_q        <= rd_type_d;
      ea_q             <= ea_d;
      ea_valid_q       <= ea_valid_d;
      busy_q           <= busy_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    rd_en_d          = 1'b0;
    wr_en_d          = 1'b0;
    rd_type_d        = `DATA_READ;
    ea_d             = ea_q;
    ea_valid_d       = 1'b0;
    busy_d           = busy_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = direct_c;
          busy_d  = 1'b1;
          state_d = instr_i[8] ? IND_RD : DONE;
          if (!instr_i[8]) ea_d = direct_c;
        end
      end
      IND_RD: begin
        mem_address_d = addr_q;
        rd_en_d       = 1'b1;
        state_d       = IND_WAIT;
      end
      IND_WAIT: begin
        // Read data belongs to the pulse issued last cycle; ea doubles as ptr.
        ea_d    = mem_read_data_i;
        state_d = ai_hit_c ? AI_NEXT : DONE;
      end
`ifdef AUTOINDEX_EN
      AI_WR: begin
        mem_address_d    = addr_q;
        mem_write_data_d = ea_q + AW'(1);
        wr_en_d          = 1'b1;
        ea_d             = ea_q + AW'(1);
        state_d          = DONE;
      end
`endif
      DONE: begin
        ea_valid_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_address_o      = mem_address_q;
  assign mem_write_data_o   = mem_write_data_q;
  assign mem_read_enable_o  = rd_en_q;
  assign mem_read_type_o    = rd_type_q;
  assign mem_write_enable_o = wr_en_q;
  assign ea_o               = ea_q;
  assign ea_valid_o         = ea_valid_q;
  assign busy_o             = busy_q;

endmodule

// File: doc/ea_sequencer.md
Name: ea_sequencer

Overview:
Memory-access initiator that resolves PDP-8 memory-reference effective addresses (EA) by driving the memory_controller request port (address, write_data, read_enable, read_type, write_enable) and consuming read_data. It handles page-zero/current-page direct addressing, indirect addressing, and autoindex pre-increment write-back for locations 0010–0017 octal. It sits between instruction decode and the memory_controller. It issues single-cycle request pulses and returns a 12-bit EA with a valid strobe.

Parameters:
AI_LO, 12'o0010, lowest autoindex address (inclusive)
AI_HI, 12'o0017, highest autoindex address (inclusive)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request EA resolution; sampled only in IDLE
instr  in  12 (word)  instruction; [8]=I (indirect), [7]=Z (1=current page), [6:0]=offset
pc  in  12 (word)  address of the instruction being resolved
mem_read_data  in  12 (word)  read_data from memory_controller
mem_address  out  12 (word)  address to memory_controller
mem_write_data  out  12 (word)  write_data to memory_controller
mem_read_enable  out  1  read request pulse
mem_read_type  out  1  read type; always `DATA_READ encoding
mem_write_enable  out  1  write request pulse
ea  out  12 (word)  resolved effective address
ea_valid  out  1  one-cycle strobe; ea is valid this cycle
busy  out  1  high from the cycle after start acceptance until ea_valid

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: mem_address=0, mem_write_data=0, mem_read_enable=0, mem_write_enable=0, mem_read_type=`DATA_READ, ea=0, ea_valid=0, busy=0, state=IDLE.
- Direct address: Z=0 -> {5'b0, offset}. Z=1 -> {pc[11:7], offset}.
- States: IDLE, IND_RD, IND_WAIT, AI_WR, DONE.
- IDLE: when start=1, latch the direct address.
  - I=0 -> DONE.
  - I=1 -> IND_RD.
  - start while not in IDLE is ignored; it is not queued.
- IND_RD: mem_address=direct address, mem_read_enable=1 for exactly this cycle -> IND_WAIT.
- IND_WAIT: enables low; capture mem_read_data as ptr.
  - If the direct address is within [AI_LO, AI_HI] -> AI_WR.
  - Otherwise ea=ptr -> DONE.
- AI_WR: mem_address=direct address, mem_write_data=ptr+1 (mod 4096, so 7777 wraps to 0000), mem_write_enable=1 for exactly this cycle. Set ea=ptr+1 -> DONE.
- DONE: ea_valid=1 for one cycle, busy=0 -> IDLE. A new start is accepted in the following cycle.
- Latency, measured from the start-sampling edge T:
  - direct: ea_valid at T+1
  - indirect: ea_valid at T+3
  - autoindex: ea_valid at T+4
- mem_read_enable and mem_write_enable are never high in the same cycle.
- ea holds its last value between strobes.
- Reset asserted in any state returns to IDLE on that edge. Enables drop and no pending write is issued.

Optional Feature:
AUTOINDEX_EN
- Defined: the autoindex path (AI_WR) behaves as described above.
- Undefined: AI_WR is not synthesized. Indirect references to 0010–0017 behave like any other indirect: no write, ea=ptr, ea_valid at T+3.

Test Plan:
- Page-zero direct: instr=12'o1025 (I=0, Z=0, off=0o25), pc=0o4200 -> ea=0o0025 at T+1; no read or write pulses.
- Current-page direct: instr Z=1, off=0o17, pc=0o4321 -> ea=0o4217 at T+1.
- Plain indirect: mem[0o0050]=0o1234; instr I=1, Z=0, off=0o50 -> one read pulse at address 0o0050 at T+1; ea=0o1234 at T+3. Also: indirect via 0o0020 (mem=0o0555) -> no write, ea=0o0555. Also: 0o0007 behaves the same way.
- Autoindex with AUTOINDEX_EN defined: mem[0o0012]=0o0777 -> read at 0o0012, write 0o1000 to 0o0012 at T+3, ea=0o1000 at T+4; memory readback of 0o0012 returns 0o1000.
  - Wrap case: mem[0o0017]=0o7777 -> writes 0o0000, ea=0o0000.
  - Without AUTOINDEX_EN: mem[0o0012] unchanged, ea=0o0777 at T+3.
- Reset and start filtering:
  - reset asserted during IND_WAIT -> next cycle busy=0, enables 0, no write issued, ea_valid stays 0.
  - start pulsed while busy -> ignored; exactly one ea_valid per accepted start.
